// File: rtl/chaos_pkg.sv
// Shared constants and types for the chaos bit sampler receive path.
package chaos_pkg;

    localparam int BYTE_W           = 8;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DIV_W_DEF        = 8;
    localparam int OVF_W_DEF        = 8;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_t;

endpackage

// File: rtl/chaos_vn_extractor.sv
// Von Neumann debiaser: pairs successive ticked bits, emits b0 when the pair differs.
//   state     | meaning
//   VN_FIRST  | waiting for first bit of a pair
//   VN_SECOND | b0 captured, next tick completes the pair
module chaos_vn_extractor
    import chaos_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    input  logic bit_in,
    input  logic vn_en,
    output logic bit_out,
    output logic bit_out_vld,
    output logic pair_half
);

    vn_state_t state_q, state_d;
    logic      b0_q, b0_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VN_FIRST;
            b0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        bit_out     = bit_in;
        bit_out_vld = 1'b0;
        if (clr) begin
            state_d = VN_FIRST;
            b0_d    = 1'b0;
        end else if (tick) begin
            if (!vn_en) begin
                bit_out_vld = 1'b1;
            end else if (state_q == VN_FIRST) begin
                state_d = VN_SECOND;
                b0_d    = bit_in;
            end else begin
                // (1,0) -> 1 and (0,1) -> 0, i.e. emit b0 when the pair differs
                state_d     = VN_FIRST;
                bit_out     = b0_q;
                bit_out_vld = (b0_q != bit_in);
            end
        end
    end

    assign pair_half = (state_q == VN_SECOND);

endmodule

// File: rtl/chaos_bit_sampler.sv
// Receive end of the chaos path: synchronize comparator, divide to sample ticks,
// optionally debias, pack MSB-first into bytes and hold them on a valid/ready port.
module chaos_bit_sampler
    import chaos_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int OVF_W       = OVF_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_W-1:0]    div,
    input  logic                vn_en,
    input  logic                cmp_in,
    output logic [BYTE_W-1:0]   byte_data,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic [OVF_W-1:0]    ovf_count,
    output logic                busy
);

    localparam int CNT_W = $clog2(BYTE_W);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_sync;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic                   vn_bit;
    logic                   vn_vld;
    logic                   pair_half;
    logic [BYTE_W-1:0]      shreg;
    logic [BYTE_W-1:0]      byte_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   byte_done;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
        end
    end

    assign cmp_sync = sync_q[SYNC_STAGES-1];

    // Equality compare on a live div: lowering div below the count wraps through max.
    assign tick = en && (div_cnt == div);

    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    chaos_vn_extractor u_vn (
        .clk         (clk),
        .rst         (rst),
        .clr         (!en),
        .tick        (tick),
        .bit_in      (cmp_sync),
        .vn_en       (vn_en),
        .bit_out     (vn_bit),
        .bit_out_vld (vn_vld),
        .pair_half   (pair_half)
    );

    assign byte_next = {shreg[BYTE_W-2:0], vn_bit};
    assign byte_done = vn_vld && (bit_cnt == CNT_W'(BYTE_W - 1));
    assign accept    = !byte_valid || byte_ready;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (vn_vld) begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_data  <= '0;
            byte_valid <= 1'b0;
            ovf_count  <= '0;
        end else if (byte_done && accept) begin
            byte_data  <= byte_next;
            byte_valid <= 1'b1;
        end else if (byte_done) begin
            if (ovf_count != '1) begin
                ovf_count <= ovf_count + OVF_W'(1);
            end
        end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

    assign busy = en && ((bit_cnt != '0) || pair_half);

endmodule

// File: doc/chaos_bit_sampler.md
Name: chaos_bit_sampler

Overview:
- Digital receive end of the tiny-chaos analog path.
- Samples the chaotic oscillator's comparator output, which arrives asynchronously on a ua-derived digital input. Optionally debiases it with a von Neumann extractor, packs the bits into bytes, and presents them on a valid/ready byte interface.
- Feeds uo_out and readout logic in the tt_um top.
- Clock is clk. Reset is rst: synchronous, active-high. The top derives rst from rst_n.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on cmp_in (minimum 2)
DIV_W, 8, width of the sample-period divider
OVF_W, 8, width of the saturating overflow counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  sampling enable
div  input  DIV_W  sample period minus one (tick every div+1 cycles)
vn_en  input  1  1 = von Neumann debias, 0 = raw bits
cmp_in  input  1  asynchronous comparator output of the chaos circuit
byte_data  output  8  completed byte, MSB = first bit emitted
byte_valid  output  1  byte_data holds an unconsumed byte
byte_ready  input  1  consumer accepts the byte when byte_valid && byte_ready
ovf_count  output  OVF_W  bytes dropped due to backpressure, saturating
busy  output  1  en && (bit_cnt != 0 || pair_half)

Behaviour:
- Reset clears everything to 0: synchronizer, divider, pair state, shift register, bit_cnt, byte_data, byte_valid, ovf_count, busy. Reset asserted mid-byte discards the partial byte and any held byte.
- Synchronizer: cmp_in passes through SYNC_STAGES flops. The synced bit lags cmp_in by SYNC_STAGES cycles.
- Divider:
  - When en=0, the counter is held at 0 and no ticks occur.
  - When en=1, the counter increments each cycle. When it equals div, tick=1 and the counter returns to 0.
  - div=0 gives a tick every cycle. div is sampled live; if div is lowered below the current count, the counter wraps through its maximum value.
- Extraction, on tick only:
  - vn_en=0: emit the synced bit.
  - vn_en=1, pair_half=0: store b0, set pair_half=1, emit nothing.
  - vn_en=1, pair_half=1: take b1 and clear pair_half. Pair (1,0) emits 1, pair (0,1) emits 0, pairs 00 and 11 emit nothing.
- Packing:
  - Each emitted bit updates shreg <= {shreg[6:0], bit} and bit_cnt <= bit_cnt+1.
  - On the 8th bit, bit_cnt returns to 0 and the byte is complete in that cycle.
- Output register:
  - A complete byte loads byte_data and sets byte_valid=1 on the next edge if byte_valid=0, or if byte_valid && byte_ready in that same cycle. In the simultaneous case byte_valid stays 1 with the new data.
  - Otherwise the new byte is dropped, the held byte is kept, and ovf_count increments, saturating at all-ones.
  - Latency from the 8th-bit tick to byte_valid=1 is one cycle.
  - byte_data is stable while byte_valid && !byte_ready.
  - byte_valid && byte_ready with no new byte clears byte_valid next cycle.
- en=0:
  - The divider, pair_half, bit_cnt and shreg clear on the next edge; the partial byte is discarded.
  - The output register and ovf_count are held, and a held byte can still be consumed.
- vn_en may only change while en=0. Changing it while en=1 is unsupported, and the bench must not do it.

Decomposition:
- Package chaos_pkg:
  - BYTE_W=8 constant.
  - Default SYNC_STAGES/DIV_W/OVF_W constants.
  - Typedef vn_state_t {VN_FIRST, VN_SECOND}.
- Sub-module chaos_vn_extractor:
  - Inputs: clk, rst, clr, tick, bit_in, vn_en.
  - Outputs: bit_out, bit_out_vld.
  - Holds pair_half/b0.
- Divider, packer and output register stay in chaos_bit_sampler.

Test Plan:
- Raw, div=0, en=1, cmp_in driven with 1,0,1,1,0,0,1,0 (one per cycle) after SYNC_STAGES settle, byte_ready=1 -> byte_data=0xB2, byte_valid high one cycle after the 8th sample.
- VN, div=0, pairs 10,01,11,10,00,01,01,10,10,01 -> 8 emitted bits 1,0,1,0,0,1,1,0 -> byte_data=0xA6; 00/11 pairs add no bit_cnt increment.
- div=3, raw, cmp_in constant 1 -> ticks every 4 cycles, byte 0xFF valid 1 cycle after the 32nd-cycle tick.
- byte_ready=0, raw div=0 alternating cmp_in for 24 cycles -> byte_data holds first byte 0xAA, ovf_count=2; raise byte_ready together with completion of 4th byte -> new byte loads, byte_valid stays 1, no overflow increment.
- en dropped after 5 raw bits, then re-raised with cmp_in=0 for 8 ticks -> next byte=0x00 (partial discarded), held byte still consumable while en=0; rst pulse mid-byte -> all outputs 0 next cycle, ovf_count=0.
